// File: rtl/ps_joiner_pkg.sv
// Shared definitions for the slice joiner: how each accepted word is classified.
package ps_joiner_pkg;

  // Classification of one accepted inbound word, highest priority first.
  typedef enum logic [2:0] {
    WC_DATA  = 3'd0,  // ordinary word inside a packet
    WC_END   = 3'd1,  // last word of the original packet
    WC_LONG  = 3'd2,  // slice ran past its expected length
    WC_SHORT = 3'd3,  // non-final slice ended early
    WC_OVF   = 3'd4   // joined packet reached its maximum length
  } word_class_t;

  // True for the classes that terminate a packet with an error.
  function automatic logic is_violation(word_class_t c);
    return (c == WC_LONG) || (c == WC_SHORT) || (c == WC_OVF);
  endfunction

endpackage

// File: rtl/ps_joiner_reg_slice.sv
// Two-entry register slice. Outputs and i_rdy come straight from flops, so
// i_rdy never depends combinationally on o_rdy.
// Handshake (both sides): a word moves when val & rdy are high on a clock
// edge; val and data are held stable by the sender until that edge.
module ps_reg_slice #(
  parameter int WIDTH = 8
) (
  input  logic             rst,
  input  logic             clk,
  input  logic [WIDTH-1:0] i_dat,
  input  logic             i_val,
  output logic             i_rdy,
  output logic [WIDTH-1:0] o_dat,
  output logic             o_val,
  input  logic             o_rdy
);

  logic [WIDTH-1:0] r_mem0;
  logic [WIDTH-1:0] r_mem1;
  logic             r_wr;
  logic             r_rd;
  logic [1:0]       r_cnt;
  logic             w_push;
  logic             w_pop;

  assign i_rdy  = (r_cnt != 2'd2);
  assign o_val  = (r_cnt != 2'd0);
  assign o_dat  = r_rd ? r_mem1 : r_mem0;
  assign w_push = i_val & i_rdy;
  assign w_pop  = o_val & o_rdy;

  // Storage, pointers and occupancy; reset empties the slice and zeroes payload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem0 <= '0;
      r_mem1 <= '0;
      r_wr   <= 1'b0;
      r_rd   <= 1'b0;
      r_cnt  <= 2'd0;
    end else begin
      if (w_push) begin
        if (r_wr) r_mem1 <= i_dat;
        else      r_mem0 <= i_dat;
        r_wr <= ~r_wr;
      end
      if (w_pop) r_rd <= ~r_rd;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/ps_joiner.sv
// Joins fixed-length slices back into packets: strips slice EOPs, restores the
// packet EOP on the i_lst slice, reports the joined length and terminates
// malformed packets with o_err.
module ps_joiner
  import ps_joiner_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int LENGTH = 4,
  parameter int MAXLEN = 256
) (
  input  logic                         rst,
  input  logic                         clk,
  input  logic [WIDTH-1:0]             i_dat,
  input  logic                         i_val,
  input  logic                         i_eop,
  input  logic                         i_lst,
  output logic                         i_rdy,
  output logic [WIDTH-1:0]             o_dat,
  output logic                         o_val,
  output logic                         o_eop,
  output logic [$clog2(MAXLEN+1)-1:0]  o_len,
  output logic                         o_err,
  input  logic                         o_rdy,
  output logic                         stat_err
);

  localparam int LW = $clog2(MAXLEN+1);
  localparam int SW = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam int PW = (MAXLEN > 1) ? $clog2(MAXLEN) : 1;

  typedef struct packed {
    logic [WIDTH-1:0] dat;
    logic             eop;
    logic             err;
    logic [LW-1:0]    len;
  } beat_t;

  localparam int BW = $bits(beat_t);

  logic [SW-1:0] r_scnt;
  logic [PW-1:0] r_pcnt;
  logic          r_stat_err;
  logic          w_acc;
  logic          w_last_slot;
  logic          w_max_len;
  logic          w_term;
  logic          w_viol;
  logic [LW-1:0] w_len_now;
  word_class_t   w_class;
  beat_t         w_beat;
  beat_t         w_obeat;

  assign w_acc       = i_val & i_rdy;
  assign w_last_slot = (r_scnt == SW'(LENGTH-1));
  assign w_max_len   = (r_pcnt == PW'(MAXLEN-1));
  assign w_len_now   = LW'(r_pcnt) + LW'(1);
  assign w_viol      = is_violation(w_class);
  assign w_term      = (w_class != WC_DATA);

  // Priority classification of the word currently offered on the input.
  always_comb begin
    w_class = WC_DATA;
    if (i_eop & i_lst)            w_class = WC_END;
    else if (~i_eop & w_last_slot) w_class = WC_LONG;
    else if (i_eop & ~w_last_slot) w_class = WC_SHORT;
    else if (w_max_len)            w_class = WC_OVF;
  end

  // Payload pushed into the register slice; length only on terminating words.
  always_comb begin
    w_beat     = '0;
    w_beat.dat = i_dat;
    w_beat.eop = w_term;
    w_beat.err = w_viol;
    w_beat.len = w_term ? w_len_now : '0;
  end

  // Slice/packet counters and the violation pulse; any termination restarts both.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scnt     <= '0;
      r_pcnt     <= '0;
      r_stat_err <= 1'b0;
    end else begin
      r_stat_err <= w_acc & w_viol;
      if (w_acc) begin
        if (w_term) begin
          r_scnt <= '0;
          r_pcnt <= '0;
        end else begin
          r_pcnt <= r_pcnt + PW'(1);
          r_scnt <= i_eop ? '0 : r_scnt + SW'(1);
        end
      end
    end
  end

  ps_reg_slice #(
    .WIDTH (BW)
  ) u_slice (
    .rst   (rst),
    .clk   (clk),
    .i_dat (w_beat),
    .i_val (i_val),
    .i_rdy (i_rdy),
    .o_dat (w_obeat),
    .o_val (o_val),
    .o_rdy (o_rdy)
  );

  assign o_dat    = w_obeat.dat;
  assign o_eop    = w_obeat.eop;
  assign o_err    = w_obeat.err;
  assign o_len    = w_obeat.len;
  assign stat_err = r_stat_err;

endmodule

// File: tb/tb_ps_joiner.sv
// Bench for ps_joiner: two instances (MAXLEN 256 and 8) share one input stream.
module tb_ps_joiner;

  localparam int LEN  = 4;
  localparam int MAXA = 256;
  localparam int MAXB = 8;

  logic       clk, rst;
  logic [7:0] i_dat;
  logic       i_val, i_eop, i_lst, o_rdy;

  logic       i_rdy_a, o_val_a, o_eop_a, o_err_a, stat_err_a;
  logic [7:0] o_dat_a;
  logic [8:0] o_len_a;
  logic       i_rdy_b, o_val_b, o_eop_b, o_err_b, stat_err_b;
  logic [7:0] o_dat_b;
  logic [3:0] o_len_b;

  ps_joiner #(.WIDTH(8), .LENGTH(LEN), .MAXLEN(MAXA)) dut_a (
    .rst(rst), .clk(clk), .i_dat(i_dat), .i_val(i_val), .i_eop(i_eop),
    .i_lst(i_lst), .i_rdy(i_rdy_a), .o_dat(o_dat_a), .o_val(o_val_a),
    .o_eop(o_eop_a), .o_len(o_len_a), .o_err(o_err_a), .o_rdy(o_rdy),
    .stat_err(stat_err_a));

  ps_joiner #(.WIDTH(8), .LENGTH(LEN), .MAXLEN(MAXB)) dut_b (
    .rst(rst), .clk(clk), .i_dat(i_dat), .i_val(i_val), .i_eop(i_eop),
    .i_lst(i_lst), .i_rdy(i_rdy_b), .o_dat(o_dat_b), .o_val(o_val_b),
    .o_eop(o_eop_b), .o_len(o_len_b), .o_err(o_err_b), .o_rdy(o_rdy),
    .stat_err(stat_err_b));

  typedef struct packed {
    logic [7:0] dat;
    logic       eop;
    logic       err;
    logic [8:0] len;
  } out_t;

  typedef struct {
    logic eop;
    logic lst;
    logic x_eop;
    logic x_err;
    int   x_len;
    bit   tgt;   // 0: expectation is for dut_a, 1: for dut_b
    bit   rb;    // reset before applying this vector
  } vec_t;

  vec_t       vecs[$];
  logic [18:0] exp_qa[$];
  logic [18:0] exp_qb[$];
  int checks = 0;
  int failures = 0;
  int m_plen[2], m_slice[2], exp_stat[2], got_stat[2], occ[2];
  bit rnd_rdy = 0;
  logic [7:0] dat_ctr;

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // output backpressure: random when enabled, otherwise always ready
  initial begin
    forever begin
      @(posedge clk);
      #1;
      o_rdy = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // Reference model: joined packet built from the rules on slice position and
  // packet length, tracked as plain counts of words seen.
  task automatic model(input int k, input int maxlen, input logic [7:0] d,
                       input logic e, input logic l, output out_t x, output bit viol);
    int plen, pos;
    plen = m_plen[k] + 1;
    pos  = m_slice[k] + 1;
    x = '0;
    x.dat = d;
    viol = 0;
    if (e && l) x.eop = 1'b1;
    else if ((!e && pos == LEN) || (e && pos != LEN) || plen == maxlen) begin
      x.eop = 1'b1;
      viol  = 1;
    end
    if (x.eop) begin
      x.err = viol;
      x.len = 9'(plen);
      m_plen[k]  = 0;
      m_slice[k] = 0;
    end else begin
      m_plen[k]  = plen;
      m_slice[k] = e ? 0 : pos;
    end
  endtask

  // scoreboard + occupancy monitor, sampled on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (stat_err_a) got_stat[0]++;
        if (stat_err_b) got_stat[1]++;
        check("rdy_a", i_rdy_a, occ[0] < 2);
        check("oval_a", o_val_a, occ[0] > 0);
        check("rdy_b", i_rdy_b, occ[1] < 2);
        check("oval_b", o_val_b, occ[1] > 0);
        if (o_val_a && o_rdy) begin
          if (exp_qa.size() == 0) begin
            checks++; failures++;
            $display("FAIL out_a unexpected word actual=%0h required=none", o_dat_a);
          end else check("out_a", {o_dat_a, o_eop_a, o_err_a, o_len_a}, exp_qa.pop_front());
        end
        if (o_val_b && o_rdy) begin
          if (exp_qb.size() == 0) begin
            checks++; failures++;
            $display("FAIL out_b unexpected word actual=%0h required=none", o_dat_b);
          end else check("out_b", {o_dat_b, o_eop_b, o_err_b, 5'b0, o_len_b}, exp_qb.pop_front());
        end
        occ[0] = occ[0] + ((i_val && i_rdy_a) ? 1 : 0) - ((o_val_a && o_rdy) ? 1 : 0);
        occ[1] = occ[1] + ((i_val && i_rdy_b) ? 1 : 0) - ((o_val_b && o_rdy) ? 1 : 0);
      end else begin
        occ[0] = 0;
        occ[1] = 0;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    #1;
    check("stat_cnt_a", got_stat[0], exp_stat[0]);
    check("stat_cnt_b", got_stat[1], exp_stat[1]);
    rst = 1'b1;
    i_val = 1'b0; i_eop = 1'b0; i_lst = 1'b0;
    @(negedge clk);
    check("rst_a", {i_rdy_a, o_val_a, o_eop_a, o_err_a, o_len_a, stat_err_a}, {1'b1, 13'b0});
    check("rst_b", {i_rdy_b, o_val_b, o_eop_b, o_err_b, o_len_b, stat_err_b}, {1'b1, 8'b0});
    exp_qa.delete();
    exp_qb.delete();
    for (int k = 0; k < 2; k++) begin
      m_plen[k] = 0; m_slice[k] = 0; exp_stat[k] = 0; got_stat[k] = 0;
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // driver: offer one word, hold until accepted; ovr replaces the model's
  // expectation for the instance selected by tgt
  task automatic send(input logic [7:0] d, input logic e, input logic l,
                      input bit ovr, input bit tgt, input out_t xo);
    bit ra, rb, done, va, vb;
    out_t xa, xb;
    i_val = 1'b1; i_dat = d; i_eop = e; i_lst = l;
    done = 0;
    for (int t = 0; t < 40 && !done; t++) begin
      @(negedge clk);
      ra = i_rdy_a;
      rb = i_rdy_b;
      @(posedge clk);
      if (ra) begin
        model(0, MAXA, d, e, l, xa, va);
        if (va) exp_stat[0]++;
        if (ovr && !tgt) xa = xo;
        exp_qa.push_back(xa);
        if (rb) begin
          model(1, MAXB, d, e, l, xb, vb);
          if (vb) exp_stat[1]++;
          if (ovr && tgt) xb = xo;
          exp_qb.push_back(xb);
        end
        done = 1;
      end
      #1;
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL send_timeout actual=not_accepted required=accepted");
    end
    i_val = 1'b0;
  endtask

  task automatic add(input bit e, input bit l, input bit xe, input bit xr,
                     input int xl, input bit tgt, input bit rb);
    vec_t v;
    v.eop = e; v.lst = l; v.x_eop = xe; v.x_err = xr; v.x_len = xl; v.tgt = tgt; v.rb = rb;
    vecs.push_back(v);
  endtask

  task automatic data(input int n, input bit tgt);
    for (int i = 0; i < n; i++) add(0, 0, 0, 0, 0, tgt, 0);
  endtask

  task automatic drain();
    i_val = 1'b0;
    repeat (2) @(posedge clk);
    for (int t = 0; t < 60 && (exp_qa.size() != 0 || exp_qb.size() != 0); t++) @(posedge clk);
    #1;
    check("drain_a", exp_qa.size(), 0);
    check("drain_b", exp_qb.size(), 0);
  endtask

  task automatic rand_words(input int n);
    int pos;
    logic e, l;
    pos = 0;
    for (int i = 0; i < n; i++) begin
      if (pos == LEN-1) e = ($urandom_range(0, 9) != 0);
      else              e = ($urandom_range(0, 7) == 0);
      l = e ? ($urandom_range(0, 2) == 0) : 1'($urandom_range(0, 1));
      send(dat_ctr, e, l, 0, 0, '0);
      dat_ctr++;
      pos = (e || pos == LEN-1) ? 0 : pos + 1;
    end
  endtask

  initial begin
    out_t xo;
    rst = 1'b1; i_val = 1'b0; i_dat = '0; i_eop = 1'b0; i_lst = 1'b0; o_rdy = 1'b1;
    dat_ctr = 8'h00;
    do_reset();

    // 1: slices 4,4,2 -> one packet of 10
    data(3, 0); add(1, 0, 0, 0, 0, 0, 0);
    data(3, 0); add(1, 0, 0, 0, 0, 0, 0);
    data(1, 0); add(1, 1, 1, 0, 10, 0, 0);
    // 2: exact multiple 4,4 then a 3-word packet
    data(3, 0); add(1, 0, 0, 0, 0, 0, 0);
    data(3, 0); add(1, 1, 1, 0, 8, 0, 0);
    data(2, 0); add(1, 1, 1, 0, 3, 0, 0);
    // 3: short non-final slice, then clean 4+1
    data(1, 0); add(1, 0, 1, 1, 2, 0, 0);
    data(3, 0); add(1, 0, 0, 0, 0, 0, 0);
    add(1, 1, 1, 0, 5, 0, 0);
    // 4: slice too long; word 5 opens a new packet
    data(3, 0); add(0, 0, 1, 1, 4, 0, 0);
    data(1, 0); add(1, 1, 1, 0, 2, 0, 0);
    // 5: MAXLEN=8 instance, slices 4,4 without i_lst
    add(0, 0, 0, 0, 0, 1, 1); data(2, 1); add(1, 0, 0, 0, 0, 1, 0);
    data(3, 1); add(1, 0, 1, 1, 8, 1, 0);

    foreach (vecs[i]) begin
      if (vecs[i].rb) begin
        drain();
        do_reset();
      end
      xo.dat = dat_ctr; xo.eop = vecs[i].x_eop; xo.err = vecs[i].x_err; xo.len = 9'(vecs[i].x_len);
      send(dat_ctr, vecs[i].eop, vecs[i].lst, 1, vecs[i].tgt, xo);
      dat_ctr++;
    end
    drain();
    do_reset();

    // 6: random backpressure, back-to-back input, reset mid-packet
    rnd_rdy = 1;
    rand_words(300);
    send(dat_ctr, 0, 0, 0, 0, '0); dat_ctr++;
    send(dat_ctr, 0, 0, 0, 0, '0); dat_ctr++;
    do_reset();
    repeat (3) begin
      send(dat_ctr, 0, 0, 0, 0, '0); dat_ctr++;
    end
    xo.dat = dat_ctr; xo.eop = 1'b1; xo.err = 1'b0; xo.len = 9'd4;
    send(dat_ctr, 1, 1, 1, 0, xo); dat_ctr++;
    rand_words(150);
    rnd_rdy = 0;
    drain();
    @(negedge clk);
    #1;
    check("stat_end_a", got_stat[0], exp_stat[0]);
    check("stat_end_b", got_stat[1], exp_stat[1]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
